// File: rtl/sede_pkg.sv
// Shared definitions for the SEDE host: image geometry, pixel/address widths
// and the host state encoding.
package sede_pkg;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int PIX_W  = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int ADDR_W = $clog2(NPIX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } host_state_t;

    // Index of the final pixel / final result slot of an image.
    function automatic logic [ADDR_W-1:0] last_index();
        return ADDR_W'(NPIX - 1);
    endfunction

endpackage

// File: rtl/sede_host_capture.sv
// Result capture path: samples edge-detector results on valid and writes them,
// one cycle later, to consecutive result-memory addresses.
// "full" marks that all NPIX results have been taken; res_cnt saturates at the
// last index instead of wrapping, so full stands in for "res_cnt == NPIX".
module sede_host_capture
    import sede_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              clear,
    input  logic              valid,
    input  logic [PIX_W-1:0]  edge_out,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [PIX_W-1:0]  res_wdata,
    output logic              full
);

    logic [ADDR_W-1:0] res_cnt;
    logic              take;

    assign take = valid && active && !full;

    // Result register, write port and result counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt   <= {ADDR_W{1'b0}};
            full      <= 1'b0;
            res_we    <= 1'b0;
            res_addr  <= {ADDR_W{1'b0}};
            res_wdata <= {PIX_W{1'b0}};
        end else begin
            res_we <= take;
            if (clear) begin
                res_cnt <= {ADDR_W{1'b0}};
                full    <= 1'b0;
            end else if (take) begin
                res_addr  <= res_cnt;
                res_wdata <= edge_out;
                if (res_cnt == last_index()) begin
                    full <= 1'b1;
                end else begin
                    res_cnt <= res_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end else begin
                res_cnt <= res_cnt;
            end
        end
    end

endmodule

// File: rtl/sede_host.sv
// SEDE host: streams one image from image memory into the edge detector and
// stores the detector results into result memory.
// Optional feature macro: SEDE_HOST_CHECK_EN adds a sticky "err" output that
// flags any edge-detector result that had to be dropped.
module sede_host
    import sede_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [PIX_W-1:0]  img_rdata,
    output logic [PIX_W-1:0]  pix_data,
    input  logic              busy,
    input  logic              valid,
    input  logic [PIX_W-1:0]  edge_out,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [PIX_W-1:0]  res_wdata,
    output logic              done
`ifdef SEDE_HOST_CHECK_EN
   ,output logic              err
`endif
);

    host_state_t       state;
    host_state_t       next_state;
    logic [ADDR_W-1:0] pix_cnt;
    logic              feeding;
    logic              accept;
    logic              last_pix;
    logic              full;

    assign feeding  = (state == ST_FEED);
    assign accept   = feeding && !busy;
    assign last_pix = (pix_cnt == last_index());

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pixel counter: advances on each accepted pixel, clears after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt <= {ADDR_W{1'b0}};
        end else if (accept) begin
            pix_cnt <= last_pix ? {ADDR_W{1'b0}} : pix_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            pix_cnt <= pix_cnt;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  next_state = start ? ST_FEED : ST_IDLE;
            ST_FEED:  next_state = (accept && last_pix) ? ST_DRAIN : ST_FEED;
            ST_DRAIN: next_state = full ? ST_DONE : ST_DRAIN;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output decode: pixel path is only live while feeding.
    always_comb begin
        img_addr = {ADDR_W{1'b0}};
        pix_data = {PIX_W{1'b0}};
        if (feeding) begin
            img_addr = pix_cnt;
            pix_data = img_rdata;
        end else begin
            img_addr = {ADDR_W{1'b0}};
            pix_data = {PIX_W{1'b0}};
        end
        done = (state == ST_DONE);
    end

    sede_host_capture u_capture (
        .clk       (clk),
        .rst       (rst),
        .active    (feeding || (state == ST_DRAIN)),
        .clear     (state == ST_DONE),
        .valid     (valid),
        .edge_out  (edge_out),
        .res_we    (res_we),
        .res_addr  (res_addr),
        .res_wdata (res_wdata),
        .full      (full)
    );

`ifdef SEDE_HOST_CHECK_EN
    logic dropped;

    assign dropped = valid && (!(feeding || (state == ST_DRAIN)) || full);

    // Sticky error flag for results that arrived when no write was possible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (dropped) begin
            err <= 1'b1;
        end else begin
            err <= err;
        end
    end
`endif

endmodule

// File: tb/tb_sede_host.sv
// Self-checking bench for sede_host: a short vector table for the first cycles
// after start, then hand-written sequences for a full image with a stall,
// result capture, dropped result, and mid-image reset.
module tb_sede_host;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] img_addr;
    logic [7:0] img_rdata;
    logic [7:0] pix_data;
    logic       busy = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] edge_out = 8'h00;
    logic       res_we;
    logic [9:0] res_addr;
    logic [7:0] res_wdata;
    logic       done;
`ifdef SEDE_HOST_CHECK_EN
    logic       err;
`endif

    int checks = 0;
    int failures = 0;

    // image[i] = i % 256, combinational read
    assign img_rdata = img_addr[7:0];

    always #5 clk = ~clk;

    sede_host dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .img_addr  (img_addr),
        .img_rdata (img_rdata),
        .pix_data  (pix_data),
        .busy      (busy),
        .valid     (valid),
        .edge_out  (edge_out),
        .res_we    (res_we),
        .res_addr  (res_addr),
        .res_wdata (res_wdata),
        .done      (done)
`ifdef SEDE_HOST_CHECK_EN
       ,.err       (err)
`endif
    );

    typedef struct {
        logic       start;
        logic       busy;
        logic       valid;
        logic [7:0] edge_out;
        logic [9:0] e_addr;
        logic [7:0] e_pix;
        logic       e_we;
        logic [9:0] e_raddr;
        logic [7:0] e_rdata;
        logic       e_done;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0; busy = 1'b0; valid = 1'b0; edge_out = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        int k;
        int stall;
        int guard;

        // ---------------- reset state ----------------
        rst = 1'b1;
        #2;
        chk("rst_img_addr", 32'(img_addr), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_res_we", 32'(res_we), 32'd0);
        chk("rst_res_addr", 32'(res_addr), 32'd0);
        chk("rst_res_wdata", 32'(res_wdata), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef SEDE_HOST_CHECK_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        tick();
        rst = 1'b0;

        // ---------------- vector table ----------------
        //           start busy  valid edge   addr   pix    we    raddr  rdata  done
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 10'd0, 8'd0, 1'b0, 10'd0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 10'd1, 8'd1, 1'b0, 10'd0, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 10'd2, 8'd2, 1'b0, 10'd0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 10'd2, 8'd2, 1'b0, 10'd0, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h55, 10'd3, 8'd3, 1'b1, 10'd0, 8'h55, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 10'd4, 8'd4, 1'b0, 10'd0, 8'h55, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'hAA, 10'd4, 8'd4, 1'b1, 10'd1, 8'hAA, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 10'd5, 8'd5, 1'b0, 10'd1, 8'hAA, 1'b0};

        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start; busy = vecs[i].busy;
            valid = vecs[i].valid; edge_out = vecs[i].edge_out;
            tick();
            chk($sformatf("vec%0d_img_addr", i), 32'(img_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_pix_data", i), 32'(pix_data), 32'(vecs[i].e_pix));
            chk($sformatf("vec%0d_res_we", i), 32'(res_we), 32'(vecs[i].e_we));
            chk($sformatf("vec%0d_res_addr", i), 32'(res_addr), 32'(vecs[i].e_raddr));
            chk($sformatf("vec%0d_res_wdata", i), 32'(res_wdata), 32'(vecs[i].e_rdata));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
        end

        // ---------------- full image with stall at pixel 96 ----------------
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cnt = 0; k = 0; stall = 0; guard = 0;
        while (exp_cnt < 1024 && guard < 2000) begin
            guard++;
            chk("feed_img_addr", 32'(img_addr), 32'(exp_cnt));
            chk("feed_pix_data", 32'(pix_data), 32'(exp_cnt % 256));
            busy = (exp_cnt == 96 && stall < 5);
            start = (exp_cnt == 300);
            valid = !busy;
            edge_out = 8'(k % 256);
            tick();
            if (busy) begin
                stall++;
                chk("stall_res_we", 32'(res_we), 32'd0);
            end else begin
                chk("feed_res_we", 32'(res_we), 32'd1);
                chk("feed_res_addr", 32'(res_addr), 32'(k));
                chk("feed_res_wdata", 32'(res_wdata), 32'(k % 256));
                chk("feed_done", 32'(done), 32'd0);
                k++;
                exp_cnt++;
            end
        end
        chk("feed_guard", 32'(guard < 2000), 32'd1);
        chk("stall_cycles", 32'(stall), 32'd5);
        busy = 1'b0; start = 1'b0;

        // now in DRAIN: pixel path idle, one extra (1025th) valid is dropped
        chk("drain_img_addr", 32'(img_addr), 32'd0);
        chk("drain_pix_data", 32'(pix_data), 32'd0);
        chk("drain_done", 32'(done), 32'd0);
        valid = 1'b1; edge_out = 8'h77;
        tick();
        valid = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("extra_res_we", 32'(res_we), 32'd0);
        chk("extra_res_addr", 32'(res_addr), 32'd1023);
        chk("extra_res_wdata", 32'(res_wdata), 32'd255);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("after_done", 32'(done), 32'd0);
            chk("after_res_we", 32'(res_we), 32'd0);
            chk("after_img_addr", 32'(img_addr), 32'd0);
`ifdef SEDE_HOST_CHECK_EN
            chk("err_sticky", 32'(err), 32'd1);
`endif
        end

        // ---------------- reset mid-image at pixel 500 ----------------
        do_reset();
`ifdef SEDE_HOST_CHECK_EN
        chk("err_cleared", 32'(err), 32'd0);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (img_addr != 10'd500 && guard < 1000) begin
            guard++;
            valid = (img_addr == 10'd10 || img_addr == 10'd20 || img_addr == 10'd499);
            edge_out = (img_addr == 10'd499) ? 8'h5A : 8'h3C;
            tick();
        end
        valid = 1'b0;
        chk("mid_guard", 32'(guard < 1000), 32'd1);
        chk("mid_res_we", 32'(res_we), 32'd1);
        chk("mid_res_addr", 32'(res_addr), 32'd2);
        chk("mid_res_wdata", 32'(res_wdata), 32'h5A);
        rst = 1'b1;
        #1;
        chk("arst_img_addr", 32'(img_addr), 32'd0);
        chk("arst_pix_data", 32'(pix_data), 32'd0);
        chk("arst_res_we", 32'(res_we), 32'd0);
        chk("arst_res_addr", 32'(res_addr), 32'd0);
        chk("arst_res_wdata", 32'(res_wdata), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        tick();
        chk("idle_no_restart", 32'(img_addr), 32'd0);
        chk("idle_pix_data", 32'(pix_data), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_addr0", 32'(img_addr), 32'd0);
        tick();
        chk("restart_addr1", 32'(img_addr), 32'd1);
        chk("restart_pix1", 32'(pix_data), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sede_host.md
SEDE_HOST -- requirements
Module: sede_host

Interface
REQ-001 IMG_W, 32, image width in pixels.
REQ-002 IMG_H, 32, image height in pixels.
REQ-003 clk  input  1  single clock, all flops on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to stream one image.
REQ-006 img_addr  output  10  image-memory read address, equal to current pixel index.
REQ-007 img_rdata  input  8  image-memory data, combinational read of img_addr.
REQ-008 pix_data  output  8  pixel to edge detector.
REQ-009 busy  input  1  edge detector stall; no pixel is consumed while high.
REQ-010 valid  input  1  edge detector result strobe.
REQ-011 edge_out  input  8  edge detector result, sampled only when valid=1.
REQ-012 res_we  output  1  result-memory write enable.
REQ-013 res_addr  output  10  result-memory write address.
REQ-014 res_wdata  output  8  result-memory write data.
REQ-015 done  output  1  one-cycle pulse, full result image written.

Function
REQ-016 States: IDLE, FEED, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE -> FEED on start=1; start outside IDLE is ignored.
REQ-018 In FEED, pix_data = img_rdata and img_addr = pix_cnt; outside FEED, pix_data = 0 and img_addr = 0.
REQ-019 A pixel is accepted at every rising edge with state FEED and busy=0; acceptance increments pix_cnt.
REQ-020 While busy=1, pix_cnt and pix_data hold; no pixel is skipped or repeated.
REQ-021 FEED -> DRAIN on acceptance of pixel IMG_W*IMG_H-1; pix_cnt then clears to 0.
REQ-022 In FEED and DRAIN, each cycle with valid=1 captures edge_out; capture is independent of busy.
REQ-023 Capture latency is one cycle: the next cycle has res_we=1, res_addr=res_cnt, res_wdata=captured edge_out; res_cnt then increments.
REQ-024 DRAIN -> DONE when res_cnt reaches IMG_W*IMG_H; DONE lasts one cycle with done=1, then -> IDLE, and res_cnt clears.
REQ-025 valid=1 in IDLE or DONE, or after IMG_W*IMG_H captures, is dropped: no write.
REQ-026 valid and the final pixel acceptance in the same cycle: both take effect.
REQ-027 Counter widths are ceil(log2(IMG_W*IMG_H)) bits; counters do not wrap.

Reset
REQ-028 rst=1 forces, asynchronously, state=IDLE, pix_cnt=0, res_cnt=0, res_we=0, res_addr=0, res_wdata=0, done=0, and err=0 when present.
REQ-029 Reset mid-image abandons the transfer; a new image requires a new start.

Configuration
REQ-030 SEDE_HOST_CHECK_EN defined: add output err (1 bit), a sticky flag set by any dropped valid (REQ-025) and cleared only by rst.
REQ-031 SEDE_HOST_CHECK_EN undefined: no err port and no check logic; all other behaviour is identical.

Structure
REQ-032 Shared package sede_pkg: IMG_W/IMG_H defaults, pixel width 8, the address width, and the host state enumeration.
REQ-033 Sub-module sede_host_capture: valid sampling, result register, res_cnt and the result-memory write port.

Verification
REQ-034 rst, then start with image[i]=i%256 and busy=0 -> img_addr 0..1023 on consecutive cycles, and DRAIN entered after pixel 1023.
REQ-035 busy held high 5 cycles at pix_cnt=96 -> pix_data holds image[96], and image[97] follows only after busy falls.
REQ-036 valid asserted 1024 times with edge_out=k%256 -> res_we pulses one cycle after each valid, res_addr 0..1023, res_wdata=k%256, done pulses once.
REQ-037 A 1025th valid, with SEDE_HOST_CHECK_EN defined -> no write, err=1 until rst.
REQ-038 rst asserted at pix_cnt=500 -> all outputs at reset values immediately; a new start restarts from img_addr=0.
REQ-039 start pulsed during FEED -> ignored, pix_cnt sequence uninterrupted.
